// File: rtl/instruction_decoder_sequencer_if.sv
// Bus between the instruction decoder/sequencer (master) and the
// program memory / computational unit side (slave).
interface instruction_decoder_sequencer_if #(
    parameter int PC_WIDTH = 8
);
    logic [7:0]          pm_data;
    logic                r_eq_0;
    logic [7:0]          from_CU;
    logic [PC_WIDTH-1:0] pm_addr;
    logic [3:0]          ir_nibble;
    logic [3:0]          source_sel;
    logic [8:0]          reg_en;
    logic                i_sel;
    logic                x_sel;
    logic                y_sel;
    logic                cu_sync_reset;
    logic                halted;

    modport master (
        input  pm_data, r_eq_0, from_CU,
        output pm_addr, ir_nibble, source_sel, reg_en, i_sel, x_sel, y_sel,
               cu_sync_reset, halted
    );

    modport slave (
        output pm_data, r_eq_0, from_CU,
        input  pm_addr, ir_nibble, source_sel, reg_en, i_sel, x_sel, y_sel,
               cu_sync_reset, halted
    );
endinterface

// File: rtl/instruction_decoder_sequencer.sv
// Two-cycle FETCH/EXEC sequencer and instruction decoder for the 4-bit datapath.
// Defining SINGLE_STEP_EN adds a step_req input and a WAIT state after each EXEC.
module instruction_decoder_sequencer #(
    parameter int                  PC_WIDTH     = 8,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic clk,
    input  logic sync_reset_n,
`ifdef SINGLE_STEP_EN
    input  logic step_req,
`endif
    instruction_decoder_sequencer_if.master bus
);

`ifdef SINGLE_STEP_EN
    typedef enum logic [1:0] {FETCH, EXEC, HALT, WAIT} state_e;
`else
    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_e;
`endif

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]          ir_q, ir_d;

    logic       isLoad, isMove, isAlu, isJnz, isJmpi, isHalt;
    logic [2:0] moveDst, moveSrc;
    logic [3:0] sourceSel;
    logic [8:0] regEn;
    logic       iSel, xSel, ySel;

    // Destination codes map straight onto reg_en bits except o_reg (code 4 -> bit 8).
    function automatic logic [8:0] dstOneHot(input logic [2:0] code);
        logic [8:0] onehot;
        onehot = '0;
        if (code == 3'd4) onehot[8] = 1'b1;
        else              onehot[code] = 1'b1;
        return onehot;
    endfunction

    assign isLoad  = ~ir_q[7];
    assign isMove  = (ir_q[7:6] == 2'b10);
    assign isAlu   = (ir_q[7:5] == 3'b110);
    assign isJnz   = (ir_q[7:4] == 4'hE);
    assign isJmpi  = (ir_q == 8'hF0);
    assign isHalt  = (ir_q == 8'hF1);
    assign moveDst = ir_q[5:3];
    assign moveSrc = ir_q[2:0];

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_VECTOR;
            ir_q    <= 8'hFF;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            FETCH: begin
                ir_d    = bus.pm_data;
                pc_d    = pc_q + 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
`ifdef SINGLE_STEP_EN
                state_d = WAIT;
`else
                state_d = FETCH;
`endif
                if (isJnz && !bus.r_eq_0) pc_d = {pc_q[PC_WIDTH-1:4], ir_q[3:0]};
                if (isJmpi)               pc_d = bus.from_CU[PC_WIDTH-1:0];
                if (isHalt)               state_d = HALT;
            end
            HALT: state_d = HALT;
`ifdef SINGLE_STEP_EN
            WAIT: if (step_req) state_d = FETCH;
`endif
            default: state_d = FETCH;
        endcase
    end

    // Writes to index register i via i+m happen whenever dm is touched, unless i is the target.
    always_comb begin
        sourceSel = 4'd0;
        regEn     = '0;
        iSel      = 1'b0;
        xSel      = 1'b0;
        ySel      = 1'b0;
        if (state_q == EXEC) begin
            if (isLoad) begin
                sourceSel = 4'd8;
                regEn     = dstOneHot(ir_q[6:4]);
                if (ir_q[6:4] == 3'd7) begin
                    regEn[6] = 1'b1;
                    iSel     = 1'b1;
                end
            end else if (isMove) begin
                sourceSel = (moveDst == moveSrc) ? 4'd9 : {1'b0, moveSrc};
                regEn     = dstOneHot(moveDst);
                if (moveDst == 3'd7 || moveSrc == 3'd7) begin
                    regEn[6] = 1'b1;
                    iSel     = (moveDst != 3'd6);
                end
            end else if (isAlu) begin
                xSel     = ir_q[4];
                ySel     = ir_q[3];
                regEn[4] = 1'b1;
            end
        end
    end

    assign bus.pm_addr       = pc_q;
    assign bus.ir_nibble     = ir_q[3:0];
    assign bus.source_sel    = sourceSel;
    assign bus.reg_en        = regEn;
    assign bus.i_sel         = iSel;
    assign bus.x_sel         = xSel;
    assign bus.y_sel         = ySel;
    assign bus.cu_sync_reset = ~sync_reset_n;
    assign bus.halted        = (state_q == HALT);

endmodule

// File: tb/tb_instruction_decoder_sequencer.sv
// Self-checking bench for instruction_decoder_sequencer: directed steps followed
// by random instruction streams checked against an instruction-level reference model.
module tb_instruction_decoder_sequencer;

    logic clk = 1'b0;
    logic syncResetN;
`ifdef SINGLE_STEP_EN
    logic stepReq;
`endif
    logic [7:0] progMem [256];
    logic [7:0] modelPc;
    logic [7:0] curInstr;
    logic [7:0] haltAddr;
    int checkCount = 0;
    int errorCount = 0;

    instruction_decoder_sequencer_if #(.PC_WIDTH(8)) ifc ();

    instruction_decoder_sequencer #(.PC_WIDTH(8), .RESET_VECTOR(8'h00)) dut (
        .clk          (clk),
        .sync_reset_n (syncResetN),
`ifdef SINGLE_STEP_EN
        .step_req     (stepReq),
`endif
        .bus          (ifc.master)
    );

    assign ifc.pm_data = progMem[ifc.pm_addr];

    always #5 clk = ~clk;

    // One clock, with sampling and driving kept 1 time unit clear of the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Expected {source_sel, reg_en, i_sel, x_sel, y_sel} for an instruction in EXEC.
    function automatic logic [15:0] refDecode(input logic [7:0] instr);
        int dst, src, sel, pos;
        logic [8:0] en;
        logic iSel, xSel, ySel;
        sel = 0; en = '0; iSel = 1'b0; xSel = 1'b0; ySel = 1'b0;
        if (instr[7] == 1'b0) begin
            dst = int'(instr[6:4]);
            sel = 8;
            pos = (dst == 4) ? 8 : dst;
            en[pos] = 1'b1;
            if (dst == 7) begin en[6] = 1'b1; iSel = 1'b1; end
        end else if (instr[7:6] == 2'b10) begin
            dst = int'(instr[5:3]);
            src = int'(instr[2:0]);
            sel = (dst == src) ? 9 : src;
            pos = (dst == 4) ? 8 : dst;
            en[pos] = 1'b1;
            if (dst == 7 || src == 7) begin en[6] = 1'b1; iSel = (dst != 6); end
        end else if (instr[7:5] == 3'b110) begin
            xSel = instr[4];
            ySel = instr[3];
            en[4] = 1'b1;
        end
        return {sel[3:0], en, iSel, xSel, ySel};
    endfunction

    function automatic logic [15:0] dutDecode();
        return {ifc.source_sel, ifc.reg_en, ifc.i_sel, ifc.x_sel, ifc.y_sel};
    endfunction

    // From FETCH: place instr at the current address and clock it into EXEC.
    task automatic applyStimulus(input logic [7:0] instr);
        checkOutput("fetch_addr", 16'(ifc.pm_addr), 16'(modelPc));
        checkOutput("fetch_regen", 16'(ifc.reg_en), 16'h0000);
        progMem[modelPc] = instr;
        curInstr = instr;
        tick();
        modelPc = modelPc + 8'd1;
    endtask

    // From EXEC: apply the jump rules to the model and clock back to FETCH.
    task automatic endExec();
        if (curInstr[7:4] == 4'hE && ifc.r_eq_0 == 1'b0) modelPc = {modelPc[7:4], curInstr[3:0]};
        if (curInstr == 8'hF0) modelPc = ifc.from_CU;
        tick();
`ifdef SINGLE_STEP_EN
        repeat (5) tick();
        checkOutput("wait_hold", 16'(ifc.pm_addr), 16'(modelPc));
        stepReq = 1'b1;
        tick();
        stepReq = 1'b0;
`endif
    endtask

    initial begin
        syncResetN = 1'b0;
        ifc.r_eq_0 = 1'b0;
        ifc.from_CU = 8'h00;
`ifdef SINGLE_STEP_EN
        stepReq = 1'b0;
`endif
        for (int i = 0; i < 256; i++) progMem[i] = 8'hFF;
        modelPc = 8'h00;
        curInstr = 8'hFF;

        $display("[TB] reset and first LOAD");
        tick(); tick();
        checkOutput("rst_cu_reset", 16'(ifc.cu_sync_reset), 16'h0001);
        checkOutput("rst_addr", 16'(ifc.pm_addr), 16'h0000);
        checkOutput("rst_halted", 16'(ifc.halted), 16'h0000);
        checkOutput("rst_nibble", 16'(ifc.ir_nibble), 16'h000F);
        syncResetN = 1'b1;
        #1;
        checkOutput("cu_reset_low", 16'(ifc.cu_sync_reset), 16'h0000);
        applyStimulus(8'h05);
        checkOutput("load_sel", 16'(ifc.source_sel), 16'h0008);
        checkOutput("load_regen", 16'(ifc.reg_en), 16'h0001);
        checkOutput("load_nibble", 16'(ifc.ir_nibble), 16'h0005);
        endExec();
        checkOutput("load_next_addr", 16'(ifc.pm_addr), 16'h0001);

        $display("[TB] MOVE and ALU decode");
        applyStimulus(8'b10_111_010);
        checkOutput("mov_dm_y0", dutDecode(), {4'd2, 9'h0C0, 1'b1, 1'b0, 1'b0});
        endExec();
        applyStimulus(8'b10_110_111);
        checkOutput("mov_i_dm", dutDecode(), {4'd7, 9'h040, 1'b0, 1'b0, 1'b0});
        endExec();
        applyStimulus(8'b10_100_100);
        checkOutput("mov_same", dutDecode(), {4'd9, 9'h100, 1'b0, 1'b0, 1'b0});
        endExec();
        applyStimulus(8'b110_1_0_010);
        checkOutput("alu", dutDecode(), {4'd0, 9'h010, 1'b0, 1'b1, 1'b0});
        checkOutput("alu_nibble", 16'(ifc.ir_nibble), 16'h0002);
        endExec();

        $display("[TB] jumps and pc wrap");
        applyStimulus(8'hF0);
        ifc.from_CU = 8'h3A;
        endExec();
        checkOutput("jmpi_3a", 16'(ifc.pm_addr), 16'h003A);
        applyStimulus(8'hE7);
        ifc.r_eq_0 = 1'b0;
        endExec();
        checkOutput("jnz_taken", 16'(ifc.pm_addr), 16'h0037);
        applyStimulus(8'hF0);
        ifc.from_CU = 8'h3A;
        endExec();
        applyStimulus(8'hE7);
        ifc.r_eq_0 = 1'b1;
        endExec();
        checkOutput("jnz_not_taken", 16'(ifc.pm_addr), 16'h003B);
        applyStimulus(8'hF0);
        ifc.from_CU = 8'hC4;
        endExec();
        checkOutput("jmpi_c4", 16'(ifc.pm_addr), 16'h00C4);
        applyStimulus(8'hF0);
        ifc.from_CU = 8'hFF;
        endExec();
        applyStimulus(8'hFF);
        checkOutput("pc_wrap", 16'(ifc.pm_addr), 16'h0000);
        checkOutput("nop_decode", dutDecode(), 16'h0000);
        endExec();

        $display("[TB] random instruction stream");
        for (int n = 0; n < 300; n++) begin
            logic [7:0] instr;
            instr = 8'($urandom);
            if (instr == 8'hF1) instr = 8'hF2;
            checkOutput("rand_not_halted", 16'(ifc.halted), 16'h0000);
            applyStimulus(instr);
            ifc.r_eq_0 = 1'($urandom);
            ifc.from_CU = 8'($urandom);
            checkOutput("rand_decode", dutDecode(), refDecode(instr));
            checkOutput("rand_nibble", 16'(ifc.ir_nibble), 16'(instr[3:0]));
            endExec();
        end

        $display("[TB] HALT and reset release");
        applyStimulus(8'hF1);
        tick();
        haltAddr = modelPc;
        checkOutput("halt_flag", 16'(ifc.halted), 16'h0001);
        for (int k = 0; k < 12; k++) begin
            progMem[ifc.pm_addr] = 8'h00;
            ifc.r_eq_0 = 1'($urandom);
            tick();
        end
        checkOutput("halt_addr_frozen", 16'(ifc.pm_addr), 16'(haltAddr));
        checkOutput("halt_ir_frozen", 16'(ifc.ir_nibble), 16'h0001);
        checkOutput("halt_regen", 16'(ifc.reg_en), 16'h0000);
        checkOutput("halt_still", 16'(ifc.halted), 16'h0001);
        syncResetN = 1'b0;
        #1;
        checkOutput("halt_cu_reset", 16'(ifc.cu_sync_reset), 16'h0001);
        tick();
        syncResetN = 1'b1;
        modelPc = 8'h00;
        checkOutput("halt_rst_addr", 16'(ifc.pm_addr), 16'h0000);
        checkOutput("halt_rst_flag", 16'(ifc.halted), 16'h0000);

        $display("[TB] reset during EXEC of LOAD");
        applyStimulus(8'h1A);
        checkOutput("load_x1_regen", 16'(ifc.reg_en), 16'h0002);
        syncResetN = 1'b0;
        #1;
        checkOutput("exec_cu_reset", 16'(ifc.cu_sync_reset), 16'h0001);
        tick();
        syncResetN = 1'b1;
        modelPc = 8'h00;
        checkOutput("exec_rst_regen", 16'(ifc.reg_en), 16'h0000);
        checkOutput("exec_rst_nibble", 16'(ifc.ir_nibble), 16'h000F);
        applyStimulus(8'hFF);
        checkOutput("exec_rst_nop", dutDecode(), 16'h0000);
        endExec();
        checkOutput("exec_rst_next", 16'(ifc.pm_addr), 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
